// File: rtl/iic_reg_ctrl_if.sv
// ============================================================================
// Module   : iic_reg_ctrl_if
// Brief    : Command/response and byte-engine signal bundle for iic_reg_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface iic_reg_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_rd;
    logic [6:0] cmd_dev;
    logic [7:0] cmd_reg;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [1:0] rsp_err;
    logic [7:0] rsp_rdata;
    logic       busy;
    logic       eng_start;
    logic       eng_continue;
    logic [7:0] eng_data_in;
    logic [7:0] eng_data_out;
    logic       eng_byte_done;
    logic       eng_ack_check;
    logic       eng_ack_check_vd;
    logic       eng_trans_done;

    // master: system register block plus byte engine; slave: the sequencer
    modport master (
        output cmd_valid, cmd_rd, cmd_dev, cmd_reg, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_err, rsp_rdata, busy,
        input  eng_start, eng_continue, eng_data_in,
        output eng_data_out, eng_byte_done, eng_ack_check, eng_ack_check_vd, eng_trans_done
    );

    modport slave (
        input  cmd_valid, cmd_rd, cmd_dev, cmd_reg, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_err, rsp_rdata, busy,
        output eng_start, eng_continue, eng_data_in,
        input  eng_data_out, eng_byte_done, eng_ack_check, eng_ack_check_vd, eng_trans_done
    );
endinterface

`default_nettype wire

// File: rtl/iic_reg_ctrl.sv
// ============================================================================
// Module   : iic_reg_ctrl
// Brief    : Single-register I2C read/write sequencer driving the byte engine,
//            with NACK detection and stall watchdog. Optional address-NACK
//            retry enabled by defining IIC_REG_CTRL_RETRY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module iic_reg_ctrl #(
    parameter int TIMEOUT_CYC = 2_000_000,
    parameter int RETRY_MAX   = 3
) (
    input  wire logic      clk,
    input  wire logic      rstn,
    iic_reg_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_DEV_W     = 3'd1,
        S_REG       = 3'd2,
        S_WDATA     = 3'd3,
        S_DEV_R     = 3'd4,
        S_RDATA     = 3'd5,
        S_WAIT_STOP = 3'd6,
        S_RESP      = 3'd7
    } state_t;

    localparam int                     c_wdog_w    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_wdog_w-1:0]    c_wdog_max  = c_wdog_w'(TIMEOUT_CYC);
    localparam logic [c_wdog_w-1:0]    c_wdog_last = c_wdog_w'(TIMEOUT_CYC - 1);

    state_t              r_state, w_state_nx;
    logic                r_rd, r_nack;
    logic [6:0]          r_dev;
    logic [7:0]          r_reg, r_wdata;
    logic [c_wdog_w-1:0] r_wdog;
    logic                r_cmd_ready, r_busy, r_rsp_valid, r_start, r_cont;
    logic [1:0]          r_rsp_err;
    logic [7:0]          r_rsp_rdata, r_data;

    logic                w_cmd_ready_nx, w_busy_nx, w_rsp_valid_nx, w_start_nx, w_cont_nx;
    logic [1:0]          w_rsp_err_nx;
    logic [7:0]          w_rsp_rdata_nx, w_data_nx;
    logic                w_accept, w_tx_state, w_nack_now, w_timeout, w_retry, w_retry_go;

    assign w_accept   = (r_state == S_IDLE) && r_cmd_ready && bus.cmd_valid;
    assign w_tx_state = (r_state == S_DEV_W) || (r_state == S_REG) ||
                        (r_state == S_WDATA) || (r_state == S_DEV_R);
    assign w_nack_now = w_tx_state && bus.eng_ack_check_vd && !bus.eng_ack_check;
    // An engine event in the same cycle clears the watchdog instead of firing it
    assign w_timeout  = (r_state != S_IDLE) && (r_state != S_RESP) && (r_wdog == c_wdog_last) &&
                        !bus.eng_byte_done && !bus.eng_trans_done;

`ifdef IIC_REG_CTRL_RETRY_EN
    localparam int                  c_retry_w   = $clog2(RETRY_MAX + 1);
    localparam logic [c_retry_w-1:0] c_retry_max = c_retry_w'(RETRY_MAX);
    logic [c_retry_w-1:0] r_retry;
    logic                 r_dev_nack;

    assign w_retry = r_nack && r_dev_nack && (r_retry != c_retry_max);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_retry    <= '0;
            r_dev_nack <= 1'b0;
        end else if (w_accept) begin
            r_retry    <= '0;
            r_dev_nack <= 1'b0;
        end else if (w_retry_go) begin
            r_retry    <= r_retry + 1'b1;
            r_dev_nack <= 1'b0;
        end else if (w_nack_now && (r_state == S_DEV_W)) begin
            r_dev_nack <= 1'b1;
        end
    end
`else
    assign w_retry = 1'b0;
`endif

    always_comb begin
        w_state_nx     = r_state;
        w_cmd_ready_nx = r_cmd_ready;
        w_busy_nx      = r_busy;
        w_rsp_valid_nx = 1'b0;
        w_rsp_err_nx   = r_rsp_err;
        w_rsp_rdata_nx = r_rsp_rdata;
        w_start_nx     = r_start;
        w_cont_nx      = r_cont;
        w_data_nx      = r_data;
        w_retry_go     = 1'b0;

        case (r_state)
            S_IDLE: if (w_accept) begin
                w_state_nx     = S_DEV_W;
                w_cmd_ready_nx = 1'b0;
                w_busy_nx      = 1'b1;
                w_data_nx      = {bus.cmd_dev, 1'b0};
                w_start_nx     = 1'b1;
                w_cont_nx      = 1'b1;
            end
            // Reads keep start high so the engine issues a repeated START after REG
            S_DEV_W: if (bus.eng_byte_done) begin
                w_state_nx = S_REG;
                w_data_nx  = r_reg;
                w_start_nx = r_rd;
                w_cont_nx  = 1'b1;
            end
            S_REG: if (bus.eng_byte_done) begin
                if (r_rd) begin
                    w_state_nx = S_DEV_R;
                    w_data_nx  = {r_dev, 1'b1};
                    w_start_nx = 1'b1;
                    w_cont_nx  = 1'b1;
                end else begin
                    w_state_nx = S_WDATA;
                    w_data_nx  = r_wdata;
                    w_start_nx = 1'b0;
                    w_cont_nx  = 1'b0;
                end
            end
            S_WDATA: if (bus.eng_byte_done) w_state_nx = S_WAIT_STOP;
            S_DEV_R: if (bus.eng_byte_done) begin
                w_state_nx = S_RDATA;
                w_start_nx = 1'b0;
                w_cont_nx  = 1'b0;
            end
            S_RDATA: if (bus.eng_byte_done) w_state_nx = S_WAIT_STOP;
            S_WAIT_STOP: if (bus.eng_trans_done) begin
                if (w_retry) begin
                    w_retry_go = 1'b1;
                    w_state_nx = S_DEV_W;
                    w_data_nx  = {r_dev, 1'b0};
                    w_start_nx = 1'b1;
                    w_cont_nx  = 1'b1;
                end else begin
                    w_state_nx     = S_RESP;
                    w_rsp_valid_nx = 1'b1;
                    w_rsp_err_nx   = r_nack ? 2'b01 : 2'b00;
                    w_rsp_rdata_nx = (r_rd && !r_nack) ? bus.eng_data_out : 8'h00;
                end
            end
            S_RESP: begin
                w_state_nx     = S_IDLE;
                w_cmd_ready_nx = 1'b1;
                w_busy_nx      = 1'b0;
                w_rsp_err_nx   = 2'b00;
                w_rsp_rdata_nx = 8'h00;
            end
            default: w_state_nx = S_IDLE;
        endcase

        if (w_nack_now) begin
            w_state_nx = S_WAIT_STOP;
            w_start_nx = 1'b0;
            w_cont_nx  = 1'b0;
            w_data_nx  = r_data;
        end

        if (w_timeout) begin
            w_state_nx     = S_RESP;
            w_start_nx     = 1'b0;
            w_cont_nx      = 1'b0;
            w_rsp_valid_nx = 1'b1;
            w_rsp_err_nx   = 2'b10;
            w_rsp_rdata_nx = 8'h00;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 2'b00;
            r_rsp_rdata <= 8'h00;
            r_start     <= 1'b0;
            r_cont      <= 1'b0;
            r_data      <= 8'h00;
        end else begin
            r_state     <= w_state_nx;
            r_cmd_ready <= w_cmd_ready_nx;
            r_busy      <= w_busy_nx;
            r_rsp_valid <= w_rsp_valid_nx;
            r_rsp_err   <= w_rsp_err_nx;
            r_rsp_rdata <= w_rsp_rdata_nx;
            r_start     <= w_start_nx;
            r_cont      <= w_cont_nx;
            r_data      <= w_data_nx;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rd    <= 1'b0;
            r_dev   <= 7'h00;
            r_reg   <= 8'h00;
            r_wdata <= 8'h00;
            r_nack  <= 1'b0;
            r_wdog  <= '0;
        end else begin
            if (w_accept) begin
                r_rd    <= bus.cmd_rd;
                r_dev   <= bus.cmd_dev;
                r_reg   <= bus.cmd_reg;
                r_wdata <= bus.cmd_wdata;
            end
            if (w_accept || w_retry_go)
                r_nack <= 1'b0;
            else if (w_nack_now)
                r_nack <= 1'b1;
            // Saturating stall counter
            if (w_accept || bus.eng_byte_done || bus.eng_trans_done)
                r_wdog <= '0;
            else if ((r_state != S_IDLE) && (r_wdog != c_wdog_max))
                r_wdog <= r_wdog + 1'b1;
        end
    end

    assign bus.cmd_ready    = r_cmd_ready;
    assign bus.busy         = r_busy;
    assign bus.rsp_valid    = r_rsp_valid;
    assign bus.rsp_err      = r_rsp_err;
    assign bus.rsp_rdata    = r_rsp_rdata;
    assign bus.eng_start    = r_start;
    assign bus.eng_continue = r_cont;
    assign bus.eng_data_in  = r_data;

endmodule

`default_nettype wire
